// File: rtl/wb_pkg.sv
// Shared types for the Wishbone command master.
// State encoding and the queued command bundle.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = WB_DAT_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP,
        RESP
    } wb_state_e;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth.
// A push while full is dropped even if a pop happens the same cycle.
module wb_cmd_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    p_clk,
    input  logic    p_reset,
    input  logic    i_push,
    input  wb_cmd_t i_data,
    input  logic    i_pop,
    output wb_cmd_t o_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);

    wb_cmd_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_cnt;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge p_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master fed by a command FIFO.
// Define WB_TIMEOUT_EN to abort silent bus cycles after TIMEOUT_CYC cycles.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_RETRY   = 3
`ifdef WB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                p_clk,
    input  logic                p_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic [WB_ADR_W-1:0] p_wb_ADR_O,
    output logic [WB_DAT_W-1:0] p_wb_DAT_O,
    input  logic [WB_DAT_W-1:0] p_wb_DAT_I,
    output logic [WB_SEL_W-1:0] p_wb_SEL_O,
    output logic                p_wb_CYC_O,
    output logic                p_wb_STB_O,
    output logic                p_wb_WE_O,
    output logic                p_wb_LOCK_O,
    input  logic                p_wb_ACK_I,
    input  logic                p_wb_ERR_I,
    input  logic                p_wb_RTY_I,
    output logic [31:0]         xfer_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    wb_state_e          r_state;
    wb_cmd_t            r_cmd;
    logic               r_cyc;
    logic               r_stb;
    logic               r_we;
    logic [RW-1:0]      r_retry;
    logic               r_rsp_valid;
    logic [WB_DAT_W-1:0] r_rsp_dat;
    logic               r_rsp_err;
    logic [31:0]        r_xfer;

    wb_cmd_t            w_in;
    wb_cmd_t            w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_live;
    logic               w_err;
    logic               w_ack;
    logic               w_rty;
    logic               w_tmo;
    logic               w_abort;

    assign w_in  = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
    assign w_pop = (r_state == IDLE) && !w_empty;

    wb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .i_push  (cmd_valid),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Slave strobes only count inside an active cycle; ERR > ACK > RTY.
    assign w_live = (r_state == BUS) && r_cyc && r_stb;
    assign w_err  = w_live && p_wb_ERR_I;
    assign w_ack  = w_live && !p_wb_ERR_I && p_wb_ACK_I;
    assign w_rty  = w_live && !p_wb_ERR_I && !p_wb_ACK_I && p_wb_RTY_I;

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo;
    assign w_tmo = w_live && !p_wb_ERR_I && !p_wb_ACK_I && !p_wb_RTY_I
                && (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge p_clk) begin
        if (p_reset || r_state != BUS) begin
            r_tmo <= '0;
        end else if (!w_tmo) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_abort = w_err || w_tmo
                  || (w_rty && int'(r_retry) >= MAX_RETRY);

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_retry     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_xfer      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_cmd   <= w_head;
                        r_we    <= w_head.we;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_retry <= '0;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    if (w_abort || w_ack || w_rty) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                    end
                    if (w_abort) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_ack) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_dat   <= r_cmd.we ? '0 : p_wb_DAT_I;
                        r_rsp_valid <= 1'b1;
                        r_xfer      <= r_xfer + 1'b1;
                        r_state     <= RESP;
                    end else if (w_rty) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= r_cmd.we;
                    r_state <= BUS;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = !w_full;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_dat     = r_rsp_dat;
    assign rsp_err     = r_rsp_err;
    assign p_wb_ADR_O  = r_cmd.adr;
    assign p_wb_DAT_O  = r_cmd.dat;
    assign p_wb_SEL_O  = r_cmd.sel;
    assign p_wb_CYC_O  = r_cyc;
    assign p_wb_STB_O  = r_stb;
    assign p_wb_WE_O   = r_we;
    assign p_wb_LOCK_O = 1'b0;
    assign xfer_cnt    = r_xfer;

endmodule
